eth_rx_frame_filter: RTL and testbench
======================================

// Module: eth_rx_frame_filter
// PURPOSE
//  Store-and-forward stage directly downstream of the MII receive MAC.
//  Buffers each received byte stream frame, then commits or discards it at tlast.
//  A frame is committed only when it has no error (tuser), passes the destination-MAC filter, is long enough, and did not overflow.
//  The upstream stream has no backpressure; the output is a full AXI4-Stream with tready for the IP/ARP consumers.
// PARAMETERS
//  DEPTH_BITS      11   buffer holds 2**DEPTH_BITS entries of {tlast,tdata[7:0]}
//  MIN_FRAME_BYTES 14   minimum frame length in bytes, counting the tlast byte; shorter frames are dropped
// PORTS
//  clock          in   1   single clock for the whole block
//  reset          in   1   asynchronous, active-high
//  saxis_tdata    in   8   received byte
//  saxis_tvalid   in   1   byte valid; no tready, every valid beat must be taken
//  saxis_tuser    in   1   1 = error on this beat (CRC or PHY error); sticky for the frame
//  saxis_tlast    in   1   last byte of frame
//  mac_address    in   48  station address; the first byte on the wire is mac_address[47:40]
//  promiscuous    in   1   1 = accept any destination address
//  maxis_tdata    out  8   frame byte
//  maxis_tvalid   out  1   output valid
//  maxis_tready   in   1   consumer ready
//  maxis_tlast    out  1   last byte of committed frame
//  drop_count     out  16  saturating count of dropped frames
//  frame_count    out  16  wrapping count of committed frames
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high.
//   - All pointers, counters and FSM states clear.
//   - maxis_tvalid, maxis_tlast, maxis_tdata, drop_count and frame_count all reset to 0.
//   - Bytes and frames in flight at reset are lost. After reset release, the block resyncs at the next beat as a frame start.
//  Pointers: wr_ptr, commit_ptr and rd_ptr are each DEPTH_BITS+1 bits wide, with the extra bit used for wrap detection.
//   - Empty: rd_ptr == commit_ptr.
//   - Full: wr_ptr - rd_ptr == 2**DEPTH_BITS.
//  Write FSM, states IDLE, HEADER, PAYLOAD, DISCARD:
//   - IDLE: a valid beat writes byte 0, sets byte_cnt = 1 and compares it with DA byte 0, then moves to HEADER.
//   - HEADER: compares bytes 1..5 against mac_address. After byte 5 it moves to PAYLOAD.
//   - DA match = (all 6 bytes equal mac_address) OR (all 6 bytes equal FF) OR promiscuous.
//   - Every beat writes at wr_ptr and increments wr_ptr and byte_cnt. byte_cnt saturates at 2**16-1.
//   - A tuser=1 beat sets a sticky bad flag for the frame.
//   - A write while full sets the overflow flag, suppresses the write and moves to DISCARD. DISCARD ignores bytes until tlast.
//  At a tlast beat (any state, including IDLE for a 1-byte frame):
//   - Commit when: !bad, !tuser, !overflow, DA match, and byte_cnt including this byte >= MIN_FRAME_BYTES.
//   - On commit: commit_ptr <= wr_ptr+1 and frame_count++.
//   - Otherwise: wr_ptr <= commit_ptr (rewind) and drop_count++ (saturates at FFFF).
//   - The FSM returns to IDLE with all flags cleared.
//   - If the tlast beat itself hits full, the frame is dropped.
//  Read side: the buffer is synchronous-read RAM feeding a single output register.
//   - A read is issued when (!maxis_tvalid || maxis_tready) && rd_ptr != commit_ptr.
//   - The register loads {tlast,tdata} one cycle after the read is issued.
//   - Latency: tlast beat accepted in cycle T, commit_ptr visible in T+1, maxis_tvalid=1 in T+2 (when the output is empty).
//   - Throughput: 1 byte/cycle while tready=1.
//   - maxis_* are held stable while tvalid && !tready.
//  Simultaneous events:
//   - A commit and a read in the same cycle are both honoured.
//   - A read frees space in the same cycle that a write tests full. The full test uses the registered rd_ptr, so this is conservative.
//   - A rewind never touches rd_ptr or data already committed.
//  Frames never interleave; committed frames leave in arrival order.
// CONFIGURATION
//  ETH_RX_FILTER_STATS_EN
//   - Defined: drop_count and frame_count counters are built as described.
//   - Undefined: both outputs are tied to 16'd0 and the counters are removed; frame filtering is otherwise identical.
// TESTING
//  1. 64-byte frame, DA = mac_address = 02:00:00:00:00:01, tuser=0 -> 64 bytes out in order, tlast on byte 64, frame_count=1.
//  2. Broadcast DA FF:FF:FF:FF:FF:FF, 60 bytes, promiscuous=0 -> forwarded; DA 02:00:00:00:00:02 -> dropped, drop_count=1, no output.
//  3. 64-byte frame with tuser=1 on last beat, then a good 64-byte frame back to back -> only the second appears; drop_count=1, frame_count=1.
//  4. DEPTH_BITS=6, maxis_tready=0, two 40-byte good frames -> first committed, second overflows and is dropped.
//     Raise tready -> exactly 40 bytes out.
//  5. 13-byte good frame, then a 1-byte frame (tlast in IDLE) -> both dropped, drop_count=2, maxis_tvalid stays 0.
//  6. reset asserted mid-frame and mid-output -> all outputs 0 immediately; next 64-byte good frame forwarded intact.
//     With ETH_RX_FILTER_STATS_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward Ethernet RX filter: commits or discards each frame at tlast.
// Optional ETH_RX_FILTER_STATS_EN builds the drop/frame counters.
module eth_rx_frame_filter #(
  parameter int DEPTH_BITS      = 11,
  parameter int MIN_FRAME_BYTES = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  saxis_tdata,
  input  logic        saxis_tvalid,
  input  logic        saxis_tuser,
  input  logic        saxis_tlast,
  input  logic [47:0] mac_address,
  input  logic        promiscuous,
  output logic [7:0]  maxis_tdata,
  output logic        maxis_tvalid,
  input  logic        maxis_tready,
  output logic        maxis_tlast,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count
);

  localparam int PW = DEPTH_BITS + 1;
  localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [15:0]     byte_cnt, cnt_n;
  logic            bad, ucast_ok, bcast_ok;
  logic            bad_n, ucast_n, bcast_n;
  logic [2:0]      hdr_idx;
  logic [7:0]      da_byte;
  logic            in_hdr, full, accept, da_match, commit, rd_en;
  logic [8:0]      mem [2**DEPTH_BITS];

  assign full   = (wr_ptr - rd_ptr) == CAP;
  assign in_hdr = (state == IDLE) || (state == HEADER);
  assign accept = saxis_tvalid && (state != DISCARD) && !full;

  always_comb begin
    hdr_idx = (state == IDLE) ? 3'd0 : byte_cnt[2:0];
    case (hdr_idx)
      3'd0:    da_byte = mac_address[47:40];
      3'd1:    da_byte = mac_address[39:32];
      3'd2:    da_byte = mac_address[31:24];
      3'd3:    da_byte = mac_address[23:16];
      3'd4:    da_byte = mac_address[15:8];
      default: da_byte = mac_address[7:0];
    endcase
  end

  // IDLE restarts the per-frame match and count accumulation
  always_comb begin
    ucast_n = ucast_ok;
    bcast_n = bcast_ok;
    if (in_hdr) begin
      ucast_n = ((state == IDLE) || ucast_ok) && (saxis_tdata == da_byte);
      bcast_n = ((state == IDLE) || bcast_ok) && (saxis_tdata == 8'hFF);
    end
    if (state == IDLE) cnt_n = 16'd1;
    else if (byte_cnt == 16'hFFFF) cnt_n = byte_cnt;
    else cnt_n = byte_cnt + 16'd1;
    bad_n    = bad || saxis_tuser;
    da_match = promiscuous || ((ucast_n || bcast_n) && (cnt_n >= 16'd6));
    commit   = saxis_tvalid && saxis_tlast && accept && !bad_n &&
               da_match && (cnt_n >= 16'(MIN_FRAME_BYTES));
  end

  always_comb begin
    state_n = state;
    if (saxis_tvalid) begin
      if (saxis_tlast) state_n = IDLE;
      else if (state == DISCARD) state_n = DISCARD;
      else if (full) state_n = DISCARD;
      else begin
        case (state)
          IDLE:    state_n = HEADER;
          HEADER:  state_n = (byte_cnt == 16'd5) ? PAYLOAD : HEADER;
          default: state_n = state;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      bad        <= 1'b0;
      ucast_ok   <= 1'b0;
      bcast_ok   <= 1'b0;
    end else if (saxis_tvalid) begin
      state <= state_n;
      if (saxis_tlast) begin
        bad      <= 1'b0;
        ucast_ok <= 1'b0;
        bcast_ok <= 1'b0;
        byte_cnt <= '0;
        if (commit) begin
          wr_ptr     <= wr_ptr + 1'b1;
          commit_ptr <= wr_ptr + 1'b1;
        end else begin
          wr_ptr <= commit_ptr;
        end
      end else begin
        bad      <= bad_n;
        ucast_ok <= ucast_n;
        bcast_ok <= bcast_n;
        if (accept) begin
          wr_ptr   <= wr_ptr + 1'b1;
          byte_cnt <= cnt_n;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[DEPTH_BITS-1:0]] <= {saxis_tlast, saxis_tdata};
  end

  // The RAM read port is the output register itself
  assign rd_en = (!maxis_tvalid || maxis_tready) && (rd_ptr != commit_ptr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      maxis_tvalid <= 1'b0;
      maxis_tlast  <= 1'b0;
      maxis_tdata  <= '0;
    end else if (rd_en) begin
      {maxis_tlast, maxis_tdata} <= mem[rd_ptr[DEPTH_BITS-1:0]];
      maxis_tvalid               <= 1'b1;
      rd_ptr                     <= rd_ptr + 1'b1;
    end else if (maxis_tready) begin
      maxis_tvalid <= 1'b0;
    end
  end

`ifdef ETH_RX_FILTER_STATS_EN
  logic drop;
  assign drop = saxis_tvalid && saxis_tlast && !commit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (commit) frame_count <= frame_count + 16'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count  = 16'd0;
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Scoreboard bench for eth_rx_frame_filter (DEPTH_BITS=6).
// Counter expectations follow ETH_RX_FILTER_STATS_EN.
module tb_eth_rx_frame_filter;

  localparam logic [47:0] MAC   = 48'h020000000001;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER = 48'h020000000002;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  saxis_tdata;
  logic        saxis_tvalid, saxis_tuser, saxis_tlast;
  logic [47:0] mac_address;
  logic        promiscuous;
  logic [7:0]  maxis_tdata;
  logic        maxis_tvalid, maxis_tready, maxis_tlast;
  logic [15:0] drop_count, frame_count;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int exp_frame = 0;
  logic [8:0] exp_q[$];

  eth_rx_frame_filter #(.DEPTH_BITS(6), .MIN_FRAME_BYTES(14)) dut (
    .clock(clock), .reset(reset),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid),
    .saxis_tuser(saxis_tuser), .saxis_tlast(saxis_tlast),
    .mac_address(mac_address), .promiscuous(promiscuous),
    .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid),
    .maxis_tready(maxis_tready), .maxis_tlast(maxis_tlast),
    .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  logic       stalled_prev = 1'b0;
  logic [8:0] held;

  // Monitor: pops the scoreboard on each handshake, checks stall stability
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        checks++;
        if (!maxis_tvalid || {maxis_tlast, maxis_tdata} !== held) begin
          errors++;
          $display("FAIL hold got v=%b %h want v=1 %h",
                   maxis_tvalid, {maxis_tlast, maxis_tdata}, held);
        end
      end
      if (maxis_tvalid && maxis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h want none",
                   {maxis_tlast, maxis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({maxis_tlast, maxis_tdata} !== e) begin
            errors++;
            $display("FAIL beat got %h want %h",
                     {maxis_tlast, maxis_tdata}, e);
          end
        end
      end
      stalled_prev = maxis_tvalid && !maxis_tready;
      held = {maxis_tlast, maxis_tdata};
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_counts(string tag);
`ifdef ETH_RX_FILTER_STATS_EN
    chk({tag, "_drop"}, 32'(drop_count), 32'(exp_drop));
    chk({tag, "_frame"}, 32'(frame_count), 32'(exp_frame));
`else
    chk({tag, "_drop"}, 32'(drop_count), 32'd0);
    chk({tag, "_frame"}, 32'(frame_count), 32'd0);
`endif
  endtask

  function automatic logic [7:0] fbyte(int i, logic [47:0] da,
                                       logic [7:0] seed);
    if (i < 6) return da[8*(5-i) +: 8];
    return seed + 8'(i);
  endfunction

  // cut>0 stops after cut bytes without tlast (frame left in flight)
  task automatic send(int len, logic [47:0] da, logic [7:0] seed,
                      bit err_last, bit push, int cut = 0);
    int n;
    n = (cut > 0) ? cut : len;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      saxis_tvalid = 1'b1;
      saxis_tdata  = fbyte(i, da, seed);
      saxis_tlast  = (cut == 0) && (i == len - 1);
      saxis_tuser  = err_last && saxis_tlast;
      if (push && cut == 0) exp_q.push_back({saxis_tlast, saxis_tdata});
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clock); #1;
      saxis_tvalid = 1'b0;
      saxis_tlast  = 1'b0;
      saxis_tuser  = 1'b0;
    end
  endtask

  task automatic drain(string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clock);
      k++;
    end
    chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    saxis_tdata = '0; saxis_tvalid = 1'b0;
    saxis_tuser = 1'b0; saxis_tlast = 1'b0;
    mac_address = MAC; promiscuous = 1'b0; maxis_tready = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("rst_tvalid", 32'(maxis_tvalid), 32'd0);
    chk("rst_tdata", 32'({maxis_tlast, maxis_tdata}), 32'd0);
    chk_counts("rst");
    @(posedge clock); #1 reset = 1'b0;

    // Unicast 64-byte frame
    send(64, MAC, 8'h10, 0, 1); exp_frame++;
    idle(1); drain("t1"); chk_counts("t1");

    // Broadcast accepted, foreign DA dropped
    send(60, BCAST, 8'h20, 0, 1); exp_frame++;
    idle(2);
    send(60, OTHER, 8'h30, 0, 0); exp_drop++;
    idle(1); drain("t2"); chk_counts("t2");

    // Error on last beat, then good frame back to back
    send(64, MAC, 8'h40, 1, 0); exp_drop++;
    send(64, MAC, 8'h50, 0, 1); exp_frame++;
    idle(1); drain("t3"); chk_counts("t3");

    // Overflow with consumer stalled
    maxis_tready = 1'b0;
    send(40, MAC, 8'h60, 0, 1); exp_frame++;
    send(40, MAC, 8'h70, 0, 0); exp_drop++;
    idle(6);
    chk("t4_stall_valid", 32'(maxis_tvalid), 32'd1);
    chk("t4_stall_data", 32'(maxis_tdata), 32'h02);
    chk_counts("t4");
    @(posedge clock); #1 maxis_tready = 1'b1;
    drain("t4"); idle(20);

    // Runt frames: 13 bytes, then a single-byte frame
    send(13, MAC, 8'h80, 0, 0); exp_drop++;
    idle(1);
    send(1, MAC, 8'h90, 0, 0); exp_drop++;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (maxis_tvalid) seen = 1'b1;
      @(posedge clock); #1;
      saxis_tvalid = 1'b0; saxis_tlast = 1'b0;
    end
    chk("t5_no_output", 32'(seen), 32'd0);
    chk_counts("t5");

    // Reset mid-output and mid-frame
    maxis_tready = 1'b0;
    send(20, MAC, 8'hA0, 0, 1); exp_frame++;
    idle(4);
    send(30, MAC, 8'hB0, 0, 0, 10);
    reset = 1'b1;
    saxis_tvalid = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(maxis_tvalid), 32'd0);
    chk("t6_rst_tlast", 32'(maxis_tlast), 32'd0);
    chk("t6_rst_tdata", 32'(maxis_tdata), 32'd0);
    exp_q.delete();
    exp_drop = 0; exp_frame = 0;
    chk_counts("t6_rst");
    @(posedge clock); #1 reset = 1'b0; maxis_tready = 1'b1;
    send(64, MAC, 8'hC0, 0, 1); exp_frame++;
    idle(1); drain("t6"); chk_counts("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
